step_pulse_gen: RTL
===================

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of delta_steps, pending backlog and motor_pos.
REQ-002 SHALL have parameter PULSE_WIDTH, default 50, clock cycles step is held high.
REQ-003 SHALL have parameter PULSE_GAP, default 50, minimum clock cycles step is held low after each pulse.
REQ-004 SHALL have parameter DIR_SETUP, default 25, clock cycles dir is stable before a step rising edge after a direction change.
REQ-005 clock  input  1  system clock, all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  high allows new pulses to start.
REQ-008 sync_sim_clock  input  1  simulator tick clock, same clock domain; one rising edge per simulation period.
REQ-009 delta_steps  input  WIDTH signed  microsteps (step/16) to add to the backlog per simulation tick.
REQ-010 step  output  1  driver STEP pulse, one pulse per microstep.
REQ-011 dir  output  1  driver DIR, 1 = positive motion.
REQ-012 motor_pos  output  WIDTH signed  microsteps actually emitted, signed running total.
REQ-013 busy  output  1  high whenever state is not IDLE or backlog is non-zero.
REQ-014 overflow  output  1  sticky, set when the backlog saturates.

Function
REQ-015 Tick detection SHALL use a registered copy sim_prev; tick = sync_sim_clock & ~sim_prev, exactly one clock cycle per rising edge.
REQ-016 On a tick, backlog SHALL become sat(backlog + delta_steps) in the next cycle, saturating to the signed WIDTH range.
REQ-017 On a tick coinciding with a pulse completion, backlog SHALL become sat(backlog + delta_steps - sign(backlog_at_pulse_start)) in one update; no update lost.
REQ-018 Saturation SHALL set overflow; overflow SHALL clear only on reset.
REQ-019 FSM states SHALL be IDLE, DIR_WAIT, PULSE_HIGH, PULSE_LOW, with one down-counter timer.
REQ-020 IDLE: if enable=1 and backlog!=0 and (backlog>0)==dir -> PULSE_HIGH, step=1, timer=PULSE_WIDTH-1.
REQ-021 IDLE: if enable=1, backlog!=0 and (backlog>0)!=dir -> dir<=(backlog>0), DIR_WAIT, timer=DIR_SETUP-1.
REQ-022 DIR_WAIT: at timer=0 -> PULSE_HIGH, step=1, timer=PULSE_WIDTH-1; otherwise decrement.
REQ-023 PULSE_HIGH: at timer=0 -> PULSE_LOW, step=0, timer=PULSE_GAP-1, backlog moved one toward zero, motor_pos +1 if dir=1 else -1 (wrap-around two's complement).
REQ-024 PULSE_LOW: at timer=0 -> IDLE; IDLE re-evaluates in that next cycle, giving step period PULSE_WIDTH+PULSE_GAP+1 cycles for back-to-back pulses.
REQ-025 enable=0 SHALL NOT abort a pulse or DIR_WAIT in progress; it only blocks leaving IDLE; backlog still accumulates.
REQ-026 If backlog reverses sign via a tick during DIR_WAIT or a pulse, the in-flight pulse SHALL still complete in the latched dir; reversal handled on return to IDLE.
REQ-027 If backlog reaches 0 before a started pulse ends (tick cancelling it), pulse completes, backlog goes to -sign, handled in IDLE.
REQ-028 step SHALL be driven directly from a flop, glitch-free.

Reset
REQ-029 reset_n=0 SHALL asynchronously force: state IDLE, step=0, dir=0, backlog=0, motor_pos=0, overflow=0, timer=0, sim_prev=1.
REQ-030 sim_prev=1 at reset SHALL suppress a spurious tick if sync_sim_clock is high when reset_n is released.
REQ-031 reset mid-pulse SHALL drop step to 0 immediately and discard the backlog.

Verification
REQ-032 Tick with delta_steps=+3, enable=1 -> dir stays 1 after one DIR_WAIT (dir was 0): dir high 25 cycles before first step; 3 pulses each 50 high/51 low; motor_pos=3; busy low after.
REQ-033 Tick delta=+2, then next tick delta=-2 after completion -> dir goes 0, DIR_WAIT 25 cycles, 2 pulses, motor_pos=0.
REQ-034 Backlog 32767 plus tick delta=+10 -> backlog 32767, overflow=1, stays 1 until reset.
REQ-035 enable=0, two ticks of +4 -> no step, busy=1, backlog=8; enable=1 -> 8 pulses, motor_pos=8.
REQ-036 Tick arriving on the exact cycle PULSE_HIGH ends with backlog=1, delta=+5 -> backlog=5 next cycle, total 6 pulses emitted.
REQ-037 reset_n pulsed low mid-PULSE_HIGH with sync_sim_clock held high, released -> step=0 immediately, no tick until next rising edge of sync_sim_clock.

Source files
------------

// File: rtl/step_pulse_gen.sv
// step_pulse_gen
// Converts a per-tick signed microstep request into STEP/DIR pulses for a
// stepper driver. Each rising edge of sync_sim_clock adds delta_steps to a
// saturating backlog. The FSM then emits one fixed-width STEP pulse per
// microstep, with a minimum low gap between pulses and a DIR setup delay
// after every direction change.
//
// Ports
//   clock          system clock, all logic on its rising edge
//   reset_n        asynchronous active-low reset
//   enable         high allows new pulses (or direction changes) to start
//   sync_sim_clock simulator tick, same clock domain; one tick per rising edge
//   delta_steps    signed microsteps added to the backlog per tick
//   step           STEP output, driven straight from a flop
//   dir            DIR output, 1 = positive motion
//   motor_pos      signed running total of emitted microsteps (wraps)
//   busy           FSM not idle or backlog non-zero
//   overflow       sticky backlog saturation flag, cleared only by reset
module step_pulse_gen #(
    parameter int WIDTH       = 16,
    parameter int PULSE_WIDTH = 50,
    parameter int PULSE_GAP   = 50,
    parameter int DIR_SETUP   = 25
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    sync_sim_clock,
    input  logic signed [WIDTH-1:0] delta_steps,
    output logic                    step,
    output logic                    dir,
    output logic signed [WIDTH-1:0] motor_pos,
    output logic                    busy,
    output logic                    overflow
);

    localparam int TMAX0 = (PULSE_WIDTH > PULSE_GAP) ? PULSE_WIDTH : PULSE_GAP;
    localparam int TMAX  = (TMAX0 > DIR_SETUP) ? TMAX0 : DIR_SETUP;
    localparam int TW    = (TMAX < 2) ? 1 : $clog2(TMAX);

    localparam logic [TW-1:0] T_HIGH = TW'(PULSE_WIDTH - 1);
    localparam logic [TW-1:0] T_LOW  = TW'(PULSE_GAP - 1);
    localparam logic [TW-1:0] T_DIR  = TW'(DIR_SETUP - 1);

    // Backlog arithmetic is done two bits wider so that backlog + delta - 1
    // can never wrap before it is clamped.
    localparam logic signed [WIDTH+1:0] BL_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] BL_MIN = {3'b111, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DIR_WAIT,
        PULSE_HIGH,
        PULSE_LOW
    } state_t;

    state_t                  state, state_nxt;
    logic [TW-1:0]           timer, timer_nxt;
    logic                    step_nxt;
    logic                    dir_nxt;
    logic                    sim_prev;
    logic                    tick;
    logic                    pulse_done;
    logic signed [WIDTH-1:0] backlog, backlog_nxt;
    logic signed [WIDTH+1:0] bl_inc, bl_dec, bl_sum;
    logic                    bl_sat;
    logic signed [WIDTH-1:0] pos_delta;
    logic                    backlog_pos;

    function automatic logic signed [WIDTH-1:0] sat_backlog(input logic signed [WIDTH+1:0] v);
        if (v > BL_MAX)
            return BL_MAX[WIDTH-1:0];
        else if (v < BL_MIN)
            return BL_MIN[WIDTH-1:0];
        else
            return v[WIDTH-1:0];
    endfunction

    function automatic logic is_saturated(input logic signed [WIDTH+1:0] v);
        return (v > BL_MAX) || (v < BL_MIN);
    endfunction

    assign tick        = sync_sim_clock & ~sim_prev;
    assign pulse_done  = (state == PULSE_HIGH) && (timer == '0);
    assign backlog_pos = !backlog[WIDTH-1] && (backlog != '0);
    assign busy        = (state != IDLE) || (backlog != '0);

    // A tick and a pulse completion in the same cycle are merged into one
    // update. The completed pulse always retires in the latched direction,
    // even if a tick has since pushed the backlog through zero.
    always_comb begin
        bl_inc = '0;
        bl_dec = '0;
        if (tick)
            bl_inc = {{2{delta_steps[WIDTH-1]}}, delta_steps};
        if (pulse_done)
            bl_dec = dir ? {{(WIDTH+1){1'b0}}, 1'b1} : {(WIDTH+2){1'b1}};
        bl_sum      = {{2{backlog[WIDTH-1]}}, backlog} + bl_inc - bl_dec;
        backlog_nxt = sat_backlog(bl_sum);
        bl_sat      = is_saturated(bl_sum);
        pos_delta   = dir ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        step_nxt  = step;
        dir_nxt   = dir;
        case (state)
            IDLE: begin
                if (enable && (backlog != '0)) begin
                    if (backlog_pos == dir) begin
                        state_nxt = PULSE_HIGH;
                        step_nxt  = 1'b1;
                        timer_nxt = T_HIGH;
                    end else begin
                        state_nxt = DIR_WAIT;
                        dir_nxt   = backlog_pos;
                        timer_nxt = T_DIR;
                    end
                end
            end
            DIR_WAIT: begin
                if (timer == '0) begin
                    state_nxt = PULSE_HIGH;
                    step_nxt  = 1'b1;
                    timer_nxt = T_HIGH;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            PULSE_HIGH: begin
                if (timer == '0) begin
                    state_nxt = PULSE_LOW;
                    step_nxt  = 1'b0;
                    timer_nxt = T_LOW;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            PULSE_LOW: begin
                if (timer == '0)
                    state_nxt = IDLE;
                else
                    timer_nxt = timer - 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                step_nxt  = 1'b0;
                timer_nxt = '0;
            end
        endcase
    end

    // sim_prev resets high so a sync_sim_clock that is already high when
    // reset is released does not count as a tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            step      <= 1'b0;
            dir       <= 1'b0;
            sim_prev  <= 1'b1;
            backlog   <= '0;
            motor_pos <= '0;
            overflow  <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            step     <= step_nxt;
            dir      <= dir_nxt;
            sim_prev <= sync_sim_clock;
            backlog  <= backlog_nxt;
            if (pulse_done)
                motor_pos <= motor_pos + pos_delta;
            if (bl_sat)
                overflow <= 1'b1;
        end
    end

endmodule
